// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus cycle sequencer:
// FSM state encoding, driver flag encodings, default phase lengths
// and the state-to-outputs decode used by generador_ciclo_rtc.
package rtc_bus_pkg;

    // Default phase lengths, in clock cycles
    localparam int CW_DEF       = 5;
    localparam int T_AD_DEF     = 4;
    localparam int T_ADH_DEF    = 2;
    localparam int T_GAP_DEF    = 2;
    localparam int T_STROBE_DEF = 15;
    localparam int T_HOLD_DEF   = 2;
    localparam int T_REC_DEF    = 5;

    // Driver flags {escritura, lectura, direccion_dato}
    localparam logic [2:0] FLAG_IDLE     = 3'b000;
    localparam logic [2:0] FLAG_ESC_DIR  = 3'b100;
    localparam logic [2:0] FLAG_ESC_DATO = 3'b101;
    localparam logic [2:0] FLAG_LEER     = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_LATCH,
        ST_GAP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVERY,
        ST_DONE
    } estado_t;

    // Every registered output of the sequencer, in one bundle
    typedef struct packed {
        logic [2:0] flags;
        logic       cs_n;
        logic       ad;
        logic       wr_n;
        logic       rd_n;
        logic       captura;
        logic       ocupado;
        logic       listo;
    } salidas_t;

    localparam salidas_t SAL_RESET = '{
        flags:   FLAG_IDLE,
        cs_n:    1'b1,
        ad:      1'b0,
        wr_n:    1'b1,
        rd_n:    1'b1,
        captura: 1'b0,
        ocupado: 1'b0,
        listo:   1'b0
    };

    // Outputs for a given state; 'ultimo' marks the final cycle of that state
    function automatic salidas_t decodificar(input estado_t st,
                                             input logic    esc,
                                             input logic    ultimo);
        salidas_t s;
        s = SAL_RESET;
        case (st)
            ST_ADDR_SETUP: begin
                s.flags   = FLAG_ESC_DIR;
                s.ad      = 1'b1;
                s.ocupado = 1'b1;
            end
            ST_ADDR_LATCH: begin
                s.flags   = FLAG_ESC_DIR;
                s.ocupado = 1'b1;
            end
            ST_GAP, ST_HOLD: begin
                s.flags   = esc ? FLAG_ESC_DATO : FLAG_LEER;
                s.cs_n    = 1'b0;
                s.ocupado = 1'b1;
            end
            ST_STROBE: begin
                s.flags   = esc ? FLAG_ESC_DATO : FLAG_LEER;
                s.cs_n    = 1'b0;
                s.wr_n    = ~esc;
                s.rd_n    = esc;
                s.captura = ~esc & ultimo;
                s.ocupado = 1'b1;
            end
            ST_RECOVERY: begin
                s.ocupado = 1'b1;
            end
            ST_DONE: begin
                s.ocupado = 1'b1;
                s.listo   = 1'b1;
            end
            default: begin
                s = SAL_RESET;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/generador_ciclo_rtc_if.sv
// Controller-side bus of the RTC cycle sequencer: start request in,
// driver flags, RTC strobes and status pulses out.
interface generador_ciclo_rtc_if;

    logic in_inicio;
    logic in_escritura;
    logic out_flag_escritura;
    logic out_flag_lectura;
    logic out_direccion_dato;
    logic out_CS_n;
    logic out_AD;
    logic out_WR_n;
    logic out_RD_n;
    logic out_captura;
    logic out_ocupado;
    logic out_listo;

    // Controller / bench side
    modport master (
        output in_inicio, in_escritura,
        input  out_flag_escritura, out_flag_lectura, out_direccion_dato,
        input  out_CS_n, out_AD, out_WR_n, out_RD_n,
        input  out_captura, out_ocupado, out_listo
    );

    // Sequencer side
    modport slave (
        input  in_inicio, in_escritura,
        output out_flag_escritura, out_flag_lectura, out_direccion_dato,
        output out_CS_n, out_AD, out_WR_n, out_RD_n,
        output out_captura, out_ocupado, out_listo
    );

endinterface

// File: rtl/contador_fase.sv
// Loadable phase down-counter. Loaded with (length - 1) on state entry,
// counts down to zero and holds there; o_fin flags the last phase cycle.
module contador_fase #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_carga,
    input  logic [CW-1:0] i_valor,
    output logic [CW-1:0] o_cuenta,
    output logic          o_fin
);

    logic [CW-1:0] r_cuenta;

    // Load on state entry, otherwise count down and stick at zero
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: only control state gets a reset; nothing here is a memory array.
        if (!reset) begin
            r_cuenta <= '0;
        end else if (i_carga) begin
            r_cuenta <= i_valor;
        end else if (r_cuenta != '0) begin
            r_cuenta <= r_cuenta - CW'(1);
        end
    end

    assign o_cuenta = r_cuenta;
    assign o_fin    = (r_cuenta == '0);

endmodule

// File: rtl/generador_ciclo_rtc.sv
// Bus-cycle sequencer for the RTC multiplexed address/data bus.
// One accepted start request produces one complete read or write cycle:
// ADDR_SETUP -> ADDR_LATCH -> GAP -> STROBE -> HOLD -> RECOVERY -> DONE.
// All outputs are registered and decoded from the next state.
// Optional macro CMD_BUFFER_EN adds a one-entry command buffer so a request
// made while busy starts right after DONE.
module generador_ciclo_rtc
    import rtc_bus_pkg::*;
#(
    parameter int T_AD     = T_AD_DEF,
    parameter int T_ADH    = T_ADH_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_REC    = T_REC_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    generador_ciclo_rtc_if.slave    bus
);

    // Counter load values: a phase of T cycles counts T-1 down to 0
    localparam logic [CW-1:0] L_AD     = CW'(T_AD - 1);
    localparam logic [CW-1:0] L_ADH    = CW'(T_ADH - 1);
    localparam logic [CW-1:0] L_GAP    = CW'(T_GAP - 1);
    localparam logic [CW-1:0] L_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] L_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_REC    = CW'(T_REC - 1);

    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic          r_escritura;
    logic          w_escritura_sig;
    salidas_t      r_sal;
    salidas_t      w_sal_sig;
    logic          w_carga;
    logic [CW-1:0] w_valor;
    logic [CW-1:0] w_cuenta;
    logic          w_fin;
    logic          w_ultimo;

`ifdef CMD_BUFFER_EN
    logic r_buf_valido;
    logic r_buf_esc;
`endif

    contador_fase #(
        .CW (CW)
    ) u_contador (
        .clk      (clk),
        .reset    (reset),
        .i_carga  (w_carga),
        .i_valor  (w_valor),
        .o_cuenta (w_cuenta),
        .o_fin    (w_fin)
    );

    // Next-state and next-operation-type decision
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_estado_sig    = r_estado;
        w_escritura_sig = r_escritura;
        case (r_estado)
            ST_IDLE: begin
                if (bus.in_inicio) begin
                    w_estado_sig    = ST_ADDR_SETUP;
                    w_escritura_sig = bus.in_escritura;
                end
            end
            ST_ADDR_SETUP: if (w_fin) w_estado_sig = ST_ADDR_LATCH;
            ST_ADDR_LATCH: if (w_fin) w_estado_sig = ST_GAP;
            ST_GAP:        if (w_fin) w_estado_sig = ST_STROBE;
            ST_STROBE:     if (w_fin) w_estado_sig = ST_HOLD;
            ST_HOLD:       if (w_fin) w_estado_sig = ST_RECOVERY;
            ST_RECOVERY:   if (w_fin) w_estado_sig = ST_DONE;
            ST_DONE: begin
                w_estado_sig = ST_IDLE;
`ifdef CMD_BUFFER_EN
                if (r_buf_valido) begin
                    w_estado_sig    = ST_ADDR_SETUP;
                    w_escritura_sig = r_buf_esc;
                end else if (bus.in_inicio) begin
                    w_estado_sig    = ST_ADDR_SETUP;
                    w_escritura_sig = bus.in_escritura;
                end
`endif
            end
            default: w_estado_sig = ST_IDLE;
        endcase
    end

    // Phase counter reload on every state change, and next-cycle outputs
    always_comb begin
        w_carga = (w_estado_sig != r_estado);
        case (w_estado_sig)
            ST_ADDR_SETUP: w_valor = L_AD;
            ST_ADDR_LATCH: w_valor = L_ADH;
            ST_GAP:        w_valor = L_GAP;
            ST_STROBE:     w_valor = L_STROBE;
            ST_HOLD:       w_valor = L_HOLD;
            ST_RECOVERY:   w_valor = L_REC;
            default:       w_valor = '0;
        endcase
        // Counter will read zero next cycle: that cycle is the last of its state
        w_ultimo  = w_carga ? (w_valor == '0) : (w_cuenta == CW'(1));
        w_sal_sig = decodificar(w_estado_sig, w_escritura_sig, w_ultimo);
    end

    // FSM state, latched operation type and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado    <= ST_IDLE;
            r_escritura <= 1'b0;
            r_sal       <= SAL_RESET;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_estado    <= w_estado_sig;
            r_escritura <= w_escritura_sig;
            r_sal       <= w_sal_sig;
        end
    end

`ifdef CMD_BUFFER_EN
    // One-entry command buffer: captures a request made mid-cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf_valido <= 1'b0;
            r_buf_esc    <= 1'b0;
        end else if (r_estado == ST_DONE) begin
            r_buf_valido <= 1'b0;
        end else if (r_estado != ST_IDLE && !r_buf_valido && bus.in_inicio) begin
            r_buf_valido <= 1'b1;
            r_buf_esc    <= bus.in_escritura;
        end
    end
`endif

    assign bus.out_flag_escritura = r_sal.flags[2];
    assign bus.out_flag_lectura   = r_sal.flags[1];
    assign bus.out_direccion_dato = r_sal.flags[0];
    assign bus.out_CS_n           = r_sal.cs_n;
    assign bus.out_AD             = r_sal.ad;
    assign bus.out_WR_n           = r_sal.wr_n;
    assign bus.out_RD_n           = r_sal.rd_n;
    assign bus.out_captura        = r_sal.captura;
    assign bus.out_ocupado        = r_sal.ocupado;
    assign bus.out_listo          = r_sal.listo;

endmodule

// File: tb/tb_generador_ciclo_rtc.sv
// Self-checking bench for generador_ciclo_rtc: a default-timing instance and
// a short-strobe corner instance, checked every cycle against a timeline
// model built from the phase lengths.
module tb_generador_ciclo_rtc;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    // Phase lengths {T_AD, T_ADH, T_GAP, T_STROBE, T_HOLD, T_REC} per instance
    int t_def [6] = '{4, 2, 2, 15, 2, 5};
    int t_esq [6] = '{4, 2, 1, 1, 2, 5};

    generador_ciclo_rtc_if if_a ();
    generador_ciclo_rtc_if if_b ();

    generador_ciclo_rtc u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    generador_ciclo_rtc #(
        .T_AD     (4),
        .T_ADH    (2),
        .T_GAP    (1),
        .T_STROBE (1),
        .T_HOLD   (2),
        .T_REC    (5),
        .CW       (5)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {flag_esc, flag_lec, dir_dato, CS_n, AD, WR_n, RD_n, captura, ocupado, listo}
    localparam logic [9:0] V_IDLE = 10'b000_1_0_1_1_0_0_0;

    function automatic logic [9:0] observado(input int sel);
        if (sel == 0)
            return {if_a.out_flag_escritura, if_a.out_flag_lectura, if_a.out_direccion_dato,
                    if_a.out_CS_n, if_a.out_AD, if_a.out_WR_n, if_a.out_RD_n,
                    if_a.out_captura, if_a.out_ocupado, if_a.out_listo};
        return {if_b.out_flag_escritura, if_b.out_flag_lectura, if_b.out_direccion_dato,
                if_b.out_CS_n, if_b.out_AD, if_b.out_WR_n, if_b.out_RD_n,
                if_b.out_captura, if_b.out_ocupado, if_b.out_listo};
    endfunction

    function automatic int largo(input int sel, input int i);
        return (sel == 0) ? t_def[i] : t_esq[i];
    endfunction

    function automatic int total(input int sel);
        int s;
        s = 0;
        for (int i = 0; i < 6; i++) s += largo(sel, i);
        return s;
    endfunction

    // Expected outputs n cycles after the accepting edge (n = 0: first address cycle)
    function automatic logic [9:0] modelo(input int sel, input int n, input bit esc);
        int fin_ad, fin_adh, fin_gap, fin_str, fin_hold, fin_rec;
        logic [2:0] f_dato;
        fin_ad   = largo(sel, 0);
        fin_adh  = fin_ad   + largo(sel, 1);
        fin_gap  = fin_adh  + largo(sel, 2);
        fin_str  = fin_gap  + largo(sel, 3);
        fin_hold = fin_str  + largo(sel, 4);
        fin_rec  = fin_hold + largo(sel, 5);
        f_dato   = esc ? 3'b101 : 3'b011;
        if (n < 0)        return V_IDLE;
        if (n < fin_ad)   return 10'b100_1_1_1_1_0_1_0;
        if (n < fin_adh)  return 10'b100_1_0_1_1_0_1_0;
        if (n < fin_gap)  return {f_dato, 7'b0_0_1_1_0_1_0};
        if (n < fin_str)  return {f_dato, 1'b0, 1'b0, ~esc, esc,
                                  (~esc && n == fin_str - 1), 1'b1, 1'b0};
        if (n < fin_hold) return {f_dato, 7'b0_0_1_1_0_1_0};
        if (n < fin_rec)  return 10'b000_1_0_1_1_0_1_0;
        if (n == fin_rec) return 10'b000_1_0_1_1_0_1_1;
        return V_IDLE;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic ini, input logic esc);
        if (sel == 0) begin
            if_a.in_inicio    = ini;
            if_a.in_escritura = esc;
        end else begin
            if_b.in_inicio    = ini;
            if_b.in_escritura = esc;
        end
    endtask

    // One full cycle from a start pulse, checked every cycle until idle again.
    // With 'mid' a second request is pulsed 10 cycles in: ignored by default,
    // chained right after DONE when the command buffer is built in.
    task automatic run_ciclo(input int sel, input bit esc, input bit mid, input bit mid_esc);
        int  n;
        int  ciclo;
        bit  esc_act;
        bit  pendiente;
        @(negedge clk);
        drive(sel, 1'b1, esc);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0);
        n         = 0;
        ciclo     = 0;
        esc_act   = esc;
        pendiente = 1'b0;
`ifdef CMD_BUFFER_EN
        pendiente = mid;
`endif
        for (int guard = 0; guard < 200; guard++) begin
            check($sformatf("sel%0d esc%0d n%0d", sel, esc_act, n),
                  observado(sel), modelo(sel, n, esc_act));
            if (mid && ciclo == 10) drive(sel, 1'b1, mid_esc);
            else                    drive(sel, 1'b0, 1'b0);
            ciclo++;
            if (n == total(sel) + 1) break;
            if (n == total(sel) && pendiente) begin
                n         = 0;
                esc_act   = mid_esc;
                pendiente = 1'b0;
            end else begin
                n++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int sel;
        bit esc;
        bit mid;
        bit mid_esc;
        int hueco;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);

        // Reset state of both instances
        #12;
        check("reset A", observado(0), V_IDLE);
        check("reset B", observado(1), V_IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle A", observado(0), V_IDLE);

        // Directed: default write, default read
        run_ciclo(0, 1'b1, 1'b0, 1'b0);
        run_ciclo(0, 1'b0, 1'b0, 1'b0);

        // Request during a busy write (a read)
        run_ciclo(0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a write strobe
        @(negedge clk);
        drive(0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        for (int n = 0; n < 13; n++) begin
            check($sformatf("pre-reset n%0d", n), observado(0), modelo(0, n, 1'b1));
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 check("async reset in strobe", observado(0), V_IDLE);
        @(posedge clk);
        #1 check("reset held", observado(0), V_IDLE);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("post-reset idle %0d", n), observado(0), V_IDLE);
        end

        // Corner instance: one-cycle gap and strobe
        run_ciclo(1, 1'b0, 1'b0, 1'b0);
        run_ciclo(1, 1'b1, 1'b0, 1'b0);

        // Randomized cycles on both instances
        for (int k = 0; k < 6; k++) begin
            sel     = int'($urandom_range(0, 1));
            esc     = 1'($urandom_range(0, 1));
            mid     = 1'($urandom_range(0, 1));
            mid_esc = 1'($urandom_range(0, 1));
            hueco   = int'($urandom_range(0, 3));
            for (int h = 0; h < hueco; h++) begin
                @(negedge clk);
                check($sformatf("gap idle sel%0d", sel), observado(sel), V_IDLE);
            end
            run_ciclo(sel, esc, mid, mid_esc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
